// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with solid / colour-bar / checkerboard / external pixel sources.
// Optional `VGA_BORDER_EN: forces a white one-pixel frame around the visible area.
module vga_timing_pattern_gen #(
    parameter int H_VISIBLE        = 640,
    parameter int H_FRONT          = 16,
    parameter int H_SYNC           = 96,
    parameter int H_BACK           = 48,
    parameter int V_VISIBLE        = 480,
    parameter int V_FRONT          = 10,
    parameter int V_SYNC           = 2,
    parameter int V_BACK           = 33,
    parameter int SYNC_ACTIVE_HIGH = 0,
    parameter int COLOR_W          = 8,
    parameter int CNT_W            = 11,
    parameter int CHECK_LOG2       = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pix_ce,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] fg_rgb,
    input  logic [3*COLOR_W-1:0] bg_rgb,
    input  logic [3*COLOR_W-1:0] ext_rgb,
    output logic [CNT_W-1:0]     pix_x,
    output logic [CNT_W-1:0]     pix_y,
    output logic                 h_sync,
    output logic                 v_sync,
    output logic                 de,
    output logic [COLOR_W-1:0]   red_out,
    output logic [COLOR_W-1:0]   green_out,
    output logic [COLOR_W-1:0]   blue_out,
    output logic                 frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int RGB_W   = 3 * COLOR_W;
    localparam int BAR_W   = H_VISIBLE / 8;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);
`ifdef VGA_BORDER_EN
    localparam logic [CNT_W-1:0] H_EDGE = CNT_W'(H_VISIBLE - 1);
    localparam logic [CNT_W-1:0] V_EDGE = CNT_W'(V_VISIBLE - 1);
`endif
    localparam logic SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

    logic [1:0]       mode_q;
    logic [1:0]       mode_eff;
    logic             visible;
    logic             hs_win;
    logic             vs_win;
    logic [3:0]       bar_idx;
    logic [RGB_W-1:0] pattern;
    logic [RGB_W-1:0] pixel;

    // Combinational so it coincides with the pix_ce that consumes pixel (0,0).
    assign frame_start = pix_ce && !reset && (pix_x == '0) && (pix_y == '0);

    // The new mode applies from pixel (0,0) of the frame that latches it.
    assign mode_eff = frame_start ? mode : mode_q;

    assign visible = (pix_x < H_VIS) && (pix_y < V_VIS);
    assign hs_win  = (pix_x >= HS_BEG) && (pix_x < HS_END);
    assign vs_win  = (pix_y >= VS_BEG) && (pix_y < VS_END);

    // Bar index 8 marks the leftover pixels past the last full bar.
    always_comb begin
        bar_idx = '0;
        for (int i = 1; i <= 8; i++)
            if (pix_x >= CNT_W'(i * BAR_W)) bar_idx = 4'(i);
    end

    always_comb begin
        pattern = '0;
        case (mode_eff)
            2'd0: pattern = fg_rgb;
            2'd1: if (!bar_idx[3])
                      pattern = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}},
                                 {COLOR_W{~bar_idx[0]}}};
            2'd2: pattern = (pix_x[CHECK_LOG2] ^ pix_y[CHECK_LOG2]) ? bg_rgb : fg_rgb;
            default: pattern = ext_rgb;
        endcase
    end

    always_comb begin
        pixel = visible ? pattern : '0;
`ifdef VGA_BORDER_EN
        if (visible && (pix_x == '0 || pix_x == H_EDGE || pix_y == '0 || pix_y == V_EDGE))
            pixel = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_x     <= '0;
            pix_y     <= '0;
            mode_q    <= 2'd0;
            h_sync    <= ~SYNC_ON;
            v_sync    <= ~SYNC_ON;
            de        <= 1'b0;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
        end else if (pix_ce) begin
            if (pix_x == H_LAST) begin
                pix_x <= '0;
                pix_y <= (pix_y == V_LAST) ? '0 : pix_y + 1'b1;
            end else begin
                pix_x <= pix_x + 1'b1;
            end
            mode_q    <= mode_eff;
            h_sync    <= hs_win ? SYNC_ON : ~SYNC_ON;
            v_sync    <= vs_win ? SYNC_ON : ~SYNC_ON;
            de        <= visible;
            red_out   <= pixel[RGB_W-1 -: COLOR_W];
            green_out <= pixel[2*COLOR_W-1 -: COLOR_W];
            blue_out  <= pixel[COLOR_W-1:0];
        end
    end

endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
- Parametrised VGA timing generator plus pixel pattern source.
- Replaces the fixed 640x480 counter/colour pair with configurable porch and sync timing, selectable test patterns, and an external-pixel pass-through.
- Runs on the system clock and advances one pixel per pixel clock-enable (25 MHz enable from a 50 MHz clock).
- All outputs are registered and mutually aligned. It sits between the clock-enable divider and the DAC/VGA pins.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_ACTIVE_HIGH, 0, 0 = syncs asserted low, 1 = asserted high
COLOR_W, 8, bits per colour channel
CNT_W, 11, width of pixel/line counters
CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
pix_ce  input  1  pixel clock-enable; state advances only when high
mode  input  2  0 solid, 1 colour bars, 2 checkerboard, 3 external
fg_rgb  input  3*COLOR_W  foreground colour {R,G,B} (solid/checker)
bg_rgb  input  3*COLOR_W  background colour {R,G,B} (checker)
ext_rgb  input  3*COLOR_W  external pixel for current pix_x/pix_y, combinational from source
pix_x  output  CNT_W  stage-0 horizontal count (pixel being fetched)
pix_y  output  CNT_W  stage-0 vertical count
h_sync  output  1  registered horizontal sync
v_sync  output  1  registered vertical sync
de  output  1  registered display-enable (visible area)
red_out / green_out / blue_out  output  COLOR_W each  registered colour
frame_start  output  1  one-clk pulse when stage 0 is at (0,0) and pix_ce=1

Behaviour:
- Timing totals: H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
- Stage 0 counters (pix_x, pix_y):
  - On pix_ce, pix_x increments; at H_TOTAL-1 it wraps to 0 and pix_y increments.
  - pix_y wraps to 0 at V_TOTAL-1 on the same cycle pix_x wraps.
  - With pix_ce low, all state holds.
- Sync windows:
  - Horizontal sync active for pix_x in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC).
  - Vertical sync active for pix_y in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC).
  - Active level follows SYNC_ACTIVE_HIGH.
- Visible area: pix_x < H_VISIBLE and pix_y < V_VISIBLE.
- Stage 1 output register:
  - On pix_ce, h_sync, v_sync, de and RGB load values computed from stage 0.
  - Latency is exactly one pix_ce from pix_x/pix_y to the outputs, and all outputs are mutually aligned.
  - When not visible, RGB loads 0 regardless of mode.
- Mode latching:
  - Active mode is a shadow register loaded from mode only on frame_start.
  - A mid-frame mode change takes effect at the next frame, so there is no tearing.
- Patterns:
  - solid = fg_rgb.
  - bars: 8 vertical bars of width H_VISIBLE/8 (integer). Order: white, yellow, cyan, green, magenta, red, blue, black. Full-scale channel = all ones.
    - Pixels beyond 8*(H_VISIBLE/8) use black.
  - checker: fg_rgb if pix_x[CHECK_LOG2] XOR pix_y[CHECK_LOG2] is 0, else bg_rgb.
  - external: ext_rgb sampled on the pix_ce cycle.
- Reset (synchronous, clk edge with reset=1):
  - Counters go to 0; active mode goes to 0.
  - de=0, RGB=0, syncs at their inactive level, frame_start=0.
  - Reset mid-line restarts at (0,0). The first pix_ce after release produces frame_start.
- Priority: reset overrides pix_ce.
- Width rule: CNT_W must hold H_TOTAL-1 and V_TOTAL-1; comparisons are unsigned.

Optional Feature:
VGA_BORDER_EN
- Defined: visible pixels with pix_x==0, pix_x==H_VISIBLE-1, pix_y==0 or pix_y==V_VISIBLE-1 output all-ones white in every mode. The override is applied before the stage-1 register, so latency is unchanged.
- Undefined: no override; the pattern is output unmodified.

Test Plan:
- Defaults, pix_ce every 2nd clk, mode=0, fg=0x102030 -> h_sync low for exactly 96 pixels starting at pixel 656; v_sync low for lines 490-491; 800x525 pix_ce per frame; de high 640x480 pixels; RGB=10/20/30 when de, 0 otherwise.
- mode=1 -> line 0 output pixels 0-79 FF/FF/FF, 80-159 FF/FF/00, ..., 560-639 00/00/00; outputs change one pix_ce after pix_x crosses each boundary.
- mode=2, fg=FFFFFF, bg=000000, CHECK_LOG2=5 -> (0,0)=white, (32,0)=black, (32,32)=white.
- Mode switched 0->1 at line 100 -> rest of frame stays solid; bars begin the pixel after the next frame_start.
- reset asserted at pix_x=300, pix_y=200 for 1 clk -> next clk: counters 0, de 0, syncs high, RGB 0; next pix_ce gives frame_start=1.
- SYNC_ACTIVE_HIGH=1 with small timing (H 8/2/2/2, V 4/1/1/1) -> h_sync high only at pixels 10-11; frame length 14*7=98 pix_ce; pix_ce held low 5 clks -> all outputs frozen.
